// File: rtl/mux_sel_arbiter_pkg.sv
// Shared encodings for the mux select arbiter: FSM states and mux select values.
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntA = 2'd1,
        StGntB = 2'd2
    } state_e;

    localparam logic SelA = 1'b0;
    localparam logic SelB = 1'b1;

    // Select value implied by a state; idle keeps whatever the mux was last pointed at.
    function automatic logic sel_of(input state_e st, input logic held);
        logic sel;
        case (st)
            StGntA:  sel = SelA;
            StGntB:  sel = SelB;
            default: sel = held;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant/select bundle between two requesters and the mux select arbiter.
interface mux_sel_arbiter_if;
    logic reqA;
    logic reqB;
    logic S;
    logic grantA;
    logic grantB;
    logic switch;

    modport master (
        output reqA,
        output reqB,
        input  S,
        input  grantA,
        input  grantB,
        input  switch
    );

    modport slave (
        input  reqA,
        input  reqB,
        output S,
        output grantA,
        output grantB,
        output switch
    );
endinterface

// File: rtl/mux_sel_arbiter_hold_counter.sv
// Dwell counter: counts cycles the waiting side has been kept off the mux, saturating at HOLD_MAX-1.
module hold_counter #(
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !at_max) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == CntMax);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 mux select, with a bounded dwell
// while the other side waits.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 3
) (
    input logic             clk,
    input logic             rst,
    mux_sel_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic             prio_b_q, prio_b_d;  // 1: B wins a simultaneous request from idle
    logic             s_q, s_d;
    logic             switch_q;
    logic             other_req;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic             at_max;

    always_comb begin
        state_d   = state_q;
        prio_b_d  = prio_b_q;
        other_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.reqA && bus.reqB) state_d = prio_b_q ? StGntB : StGntA;
                else if (bus.reqA)        state_d = StGntA;
                else if (bus.reqB)        state_d = StGntB;
            end
            StGntA: begin
                other_req = bus.reqB;
                if (!bus.reqA)                state_d = bus.reqB ? StGntB : StIdle;
                else if (bus.reqB && at_max)  state_d = StGntB;
            end
            StGntB: begin
                other_req = bus.reqA;
                if (!bus.reqB)                state_d = bus.reqA ? StGntA : StIdle;
                else if (bus.reqA && at_max)  state_d = StGntA;
            end
            default: state_d = StIdle;
        endcase

        // Every grant entry hands priority to the side that just lost.
        if (state_d != state_q && state_d != StIdle) begin
            prio_b_d = (state_d == StGntA);
        end

        cnt_clr = (state_d != state_q) || (state_q == StIdle) || !other_req;
        s_d     = sel_of(state_d, s_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            prio_b_q <= 1'b0;
            s_q      <= SelA;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_b_q <= prio_b_d;
            s_q      <= s_d;
            switch_q <= (s_d != s_q);
        end
    end

    hold_counter #(
        .CNT_W    (CNT_W),
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (other_req),
        .cnt    (cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt <= CntMax);
        end
    end

    assign bus.S      = s_q;
    assign bus.grantA = (state_q == StGntA);
    assign bus.grantB = (state_q == StGntB);
    assign bus.switch = switch_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Randomized and directed bench for mux_sel_arbiter at HOLD_MAX=4 and HOLD_MAX=1, against an
// ownership-level reference model.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] mux_a, mux_b;

    always #5 clk = ~clk;

    mux_sel_arbiter_if if4 ();
    mux_sel_arbiter_if if1 ();

    mux_sel_arbiter #(.HOLD_MAX(4), .CNT_W(3)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    mux_sel_arbiter #(.HOLD_MAX(1), .CNT_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Behavioural mux2_to_1 fed by each arbiter's select.
    wire [7:0] z4 = if4.S ? mux_b : mux_a;
    wire [7:0] z1 = if1.S ? mux_b : mux_a;

    int n_vec = 0;
    int n_err = 0;

    // Model: owner 0=none 1=A 2=B; prio names the side that wins a tie from idle.
    int m_own   [2];
    int m_dwell [2];
    int m_prio  [2];
    bit m_s     [2];
    bit m_sw    [2];
    int hold    [2] = '{4, 1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit a, input bit b);
        int nxt;
        bit other;
        bit ns;
        if (r) begin
            m_own[k] = 0; m_dwell[k] = 0; m_prio[k] = 1; m_s[k] = 1'b0; m_sw[k] = 1'b0;
            return;
        end
        case (m_own[k])
            1:       nxt = !a ? (b ? 2 : 0) : ((b && m_dwell[k] == hold[k] - 1) ? 2 : 1);
            2:       nxt = !b ? (a ? 1 : 0) : ((a && m_dwell[k] == hold[k] - 1) ? 1 : 2);
            default: nxt = (a && b) ? m_prio[k] : (a ? 1 : (b ? 2 : 0));
        endcase
        other = (m_own[k] == 1) ? b : ((m_own[k] == 2) ? a : 1'b0);
        if (nxt != m_own[k] || nxt == 0 || !other) m_dwell[k] = 0;
        else m_dwell[k] = (m_dwell[k] + 1 > hold[k] - 1) ? hold[k] - 1 : m_dwell[k] + 1;
        if (nxt != 0 && nxt != m_own[k]) m_prio[k] = 3 - nxt;
        ns       = (nxt == 1) ? 1'b0 : ((nxt == 2) ? 1'b1 : m_s[k]);
        m_sw[k]  = (ns != m_s[k]);
        m_s[k]   = ns;
        m_own[k] = nxt;
    endtask

    task automatic check_inst(input string name, input int k, input logic ga, input logic gb,
                              input logic s, input logic sw, input logic [7:0] z);
        check_eq({name, ".grantA"}, 32'(ga), 32'(m_own[k] == 1));
        check_eq({name, ".grantB"}, 32'(gb), 32'(m_own[k] == 2));
        check_eq({name, ".S"},      32'(s),  32'(m_s[k]));
        check_eq({name, ".switch"}, 32'(sw), 32'(m_sw[k]));
        check_eq({name, ".onehot"}, 32'(ga & gb), 32'(0));
        check_eq({name, ".Z"},      32'(z),  32'(m_s[k] ? mux_b : mux_a));
    endtask

    task automatic tick(input bit r, input bit a, input bit b);
        rst = r;
        if4.reqA = a; if4.reqB = b;
        if1.reqA = a; if1.reqB = b;
        mux_a = 8'($urandom);
        mux_b = 8'($urandom);
        @(posedge clk);
        #1;
        model_step(0, r, a, b);
        model_step(1, r, a, b);
        check_inst("h4", 0, if4.grantA, if4.grantB, if4.S, if4.switch, z4);
        check_inst("h1", 1, if1.grantA, if1.grantB, if1.S, if1.switch, z1);
    endtask

    initial begin
        bit ra, rb;
        for (int k = 0; k < 2; k++) model_step(k, 1'b1, 1'b0, 1'b0);

        // Reset held with both requesting, then sustained contention.
        repeat (2) tick(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            check_eq("cont4.grantA", 32'(if4.grantA), 32'(i <= 4 || i >= 9));
            check_eq("cont4.switch", 32'(if4.switch), 32'(i == 5 || i == 9));
            if (i <= 6) begin
                check_eq("alt1.grantA", 32'(if1.grantA), 32'(i % 2 == 1));
                check_eq("alt1.switch", 32'(if1.switch), 32'(i > 1));
            end
        end

        // Single requesters.
        tick(1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        check_eq("single.S_held", 32'(if4.S), 32'(1));

        // Handoff A -> B without an idle bubble.
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("handoff.grantB", 32'(if4.grantB), 32'(1));
        tick(1'b0, 1'b0, 1'b0);

        // Reset while B holds with A waiting.
        tick(1'b0, 1'b0, 1'b1);
        repeat (2) tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check_eq("midrst.S", 32'(if4.S), 32'(0));
        tick(1'b0, 1'b1, 1'b1);
        check_eq("midrst.prioA", 32'(if4.grantA), 32'(1));

        // Random traffic with occasional resets.
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            tick($urandom_range(0, 63) == 0, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
